// File: rtl/uart_lite_pkg.sv
// Shared definitions for the AXI4-Lite UART front end: register word
// indices (address bits [4:2]), AXI response codes and channel FSM states.
// Optional build macro used by the design: UART_LITE_LOOPBACK_EN.
package uart_lite_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_IER    = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/uart_lite_fifo.sv
// Synchronous byte FIFO with an extra pointer MSB for full/empty
// distinction. A push on a full FIFO is accepted only when a pop happens
// in the same cycle; flush empties the FIFO and overrides push/pop.
module uart_lite_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_pop_ok;
    logic              w_push_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count   = r_wptr - r_rptr;
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Pointer and storage update; flush returns both pointers to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr[AW-1:0]] <= i_push_data;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_uart_lite.sv
// AXI4-Lite slave UART front end: TX/RX byte FIFOs, DATA/IER/STATUS/CTRL
// registers and a registered level interrupt. Build macro
// UART_LITE_LOOPBACK_EN adds the CTRL[2] internal TX->RX loopback.
module axil_uart_lite
    import uart_lite_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  chipset_clk,
    input  logic                  chipset_rstn,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  uart_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t             r_wstate;
    rd_state_t             r_rstate;
    logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_aw_held, r_w_held;
    logic [ADDR_W-1:0]     r_awaddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [1:0]            r_ier;
    logic                  r_overrun, r_tx_flush, r_rx_flush, r_irq;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [DATA_W-1:0]     w_wr_data;
    logic [DATA_W/8-1:0]   w_wr_strb;
    logic [2:0]            w_wr_idx, w_ar_idx;
    logic [1:0]            w_wr_resp;
    logic [DATA_W-1:0]     w_rd_data;
    logic                  w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic                  w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
    logic [7:0]            w_tx_head, w_rx_head, w_rx_push_data;
    logic [CW-1:0]         w_tx_count, w_rx_count;
    logic                  w_ier_wr, w_ctrl_wr, w_status_rd, w_loopback;
    logic                  w_unused;

`ifdef UART_LITE_LOOPBACK_EN
    logic                  r_loopback;
    assign w_loopback = r_loopback;
`else
    assign w_loopback = 1'b0;
`endif

    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid && r_wready;
    assign w_ar_hs   = s_axi_arvalid && r_arready;
    assign w_wr_addr = w_aw_hs ? s_axi_awaddr : r_awaddr;
    assign w_wr_data = w_w_hs ? s_axi_wdata : r_wdata;
    assign w_wr_strb = w_w_hs ? s_axi_wstrb : r_wstrb;
    assign w_wr_idx  = w_wr_addr[4:2];
    assign w_ar_idx  = s_axi_araddr[4:2];
    assign w_wr_fire = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_ier_wr    = w_wr_fire && (w_wr_idx == REG_IER) && w_wr_strb[0];
    assign w_ctrl_wr   = w_wr_fire && (w_wr_idx == REG_CTRL) && w_wr_strb[0];
    assign w_status_rd = w_ar_hs && (w_ar_idx == REG_STATUS);

    // RX pop on a DATA read; a pending RX flush takes priority over it.
    assign w_rx_pop  = w_ar_hs && (w_ar_idx == REG_DATA) && !w_rx_empty && !r_rx_flush;
    // In loopback the TX head drains into RX whenever RX can take it.
    assign w_tx_pop  = w_loopback ? (!w_tx_empty && (!w_rx_full || w_rx_pop))
                                  : (!w_tx_empty && tx_ready);
    assign w_rx_push      = w_loopback ? w_tx_pop : rx_valid;
    assign w_rx_push_data = w_loopback ? w_tx_head : rx_data;
    assign w_rx_drop      = w_rx_push && w_rx_full && !w_rx_pop;

    assign w_unused = &{1'b0, w_wr_addr, w_wr_data, w_wr_strb, s_axi_araddr, w_tx_count};

    // Write-side register action: TX push or SLVERR when the byte is dropped.
    always_comb begin
        w_tx_push = 1'b0;
        w_wr_resp = RESP_OKAY;
        if (w_wr_fire && (w_wr_idx == REG_DATA) && w_wr_strb[0]) begin
            if (w_tx_full && !w_tx_pop) begin
                w_wr_resp = RESP_SLVERR;
            end else begin
                w_tx_push = 1'b1;
            end
        end else begin
            w_tx_push = 1'b0;
        end
    end

    // Read data mux for the register addressed by the AR handshake.
    always_comb begin
        w_rd_data = '0;
        case (w_ar_idx)
            REG_DATA: begin
                if (!w_rx_empty) begin
                    w_rd_data[7:0] = w_rx_head;
                end else begin
                    w_rd_data = '0;
                end
            end
            REG_IER:    w_rd_data[1:0] = r_ier;
            REG_STATUS: begin
                w_rd_data[15:8] = 8'(w_rx_count);
                w_rd_data[3:0]  = {r_overrun, w_tx_full, w_tx_empty, !w_rx_empty};
            end
            REG_CTRL:   w_rd_data[2] = w_loopback;
            default:    w_rd_data = '0;
        endcase
    end

    // Write channel FSM: latch AW and W independently, then respond once.
    always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
        if (!chipset_rstn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_fire) begin
                        r_wstate  <= W_RESP;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_resp;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s_axi_awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axi_wdata;
                            r_wstrb  <= s_axi_wstrb;
                        end
                        r_awready <= !(r_aw_held || w_aw_hs);
                        r_wready  <= !(r_w_held || w_w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end else begin
                        r_bvalid <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: capture read data at AR and hold it until rready.
    always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
        if (!chipset_rstn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= RESP_OKAY;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end else begin
                        r_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b0;
                end
            endcase
        end
    end

    // Control state: IER, one-cycle flush pulses, sticky overrun, loopback.
    always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
        if (!chipset_rstn) begin
            r_ier      <= 2'b00;
            r_tx_flush <= 1'b0;
            r_rx_flush <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef UART_LITE_LOOPBACK_EN
            r_loopback <= 1'b0;
`endif
        end else begin
            r_tx_flush <= w_ctrl_wr && w_wr_data[0];
            r_rx_flush <= w_ctrl_wr && w_wr_data[1];
            if (w_ier_wr) begin
                r_ier <= w_wr_data[1:0];
            end else begin
                r_ier <= r_ier;
            end
            if (w_rx_drop) begin
                r_overrun <= 1'b1;
            end else if (w_status_rd) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
`ifdef UART_LITE_LOOPBACK_EN
            if (w_ctrl_wr) begin
                r_loopback <= w_wr_data[2];
            end else begin
                r_loopback <= r_loopback;
            end
`endif
        end
    end

    // Registered level interrupt from the enabled FIFO conditions.
    always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
        if (!chipset_rstn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_ier[0] && !w_rx_empty) || (r_ier[1] && w_tx_empty);
        end
    end

    uart_lite_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk       (chipset_clk),
        .i_rst_n     (chipset_rstn),
        .i_flush     (r_tx_flush),
        .i_push      (w_tx_push),
        .i_push_data (w_wr_data[7:0]),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_count     (w_tx_count)
    );

    uart_lite_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk       (chipset_clk),
        .i_rst_n     (chipset_rstn),
        .i_flush     (r_rx_flush),
        .i_push      (w_rx_push),
        .i_push_data (w_rx_push_data),
        .i_pop       (w_rx_pop),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count)
    );

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign tx_valid      = !w_tx_empty && !w_loopback;
    assign tx_data       = w_tx_head;
    assign uart_irq      = r_irq;

endmodule
